// File: rtl/i2s_tx.sv
// i2s_tx: Philips-format I2S master transmitter.
// Accepts stereo sample pairs over a valid/ready handshake into a one-deep
// holding register and serialises them as BCLK/WS/DATA, MSB first.
// Data, WS and the frame pulses all change in the clk_sys cycle in which BCLK
// falls, so a receiver sampling on the BCLK rising edge sees stable values.
// Handshake: a pair is taken on any clk_sys edge where sample_valid and
// sample_ready are both high; sample_ready is high exactly while the holding
// register is empty, and inputs are ignored while it is low.
module i2s_tx #(
   parameter int CLK_DIV   = 8,
   parameter int SAMPLE_W  = 16,
   parameter int SLOT_BITS = 16
) (
   input  logic                clk_sys,
   input  logic                RESET,
   input  logic                en,
   input  logic [SAMPLE_W-1:0] sample_l,
   input  logic [SAMPLE_W-1:0] sample_r,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic                i2s_bclk,
   output logic                i2s_ws,
   output logic                i2s_data,
   output logic                frame_start,
   output logic                underrun
);

   localparam int FW = 2 * SLOT_BITS;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PW = $clog2(FW);

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [PW-1:0] P_LAST   = PW'(FW - 1);
   localparam logic [PW-1:0] WS_LO    = PW'(SLOT_BITS - 1);
   localparam logic [PW-1:0] WS_HI    = PW'(FW - 2);

   logic [DW-1:0]       div;
   logic [PW-1:0]       pos;
   logic [FW-1:0]       frame_sr;
   logic [SAMPLE_W-1:0] hold_l;
   logic [SAMPLE_W-1:0] hold_r;
   logic                hold_full;

   logic                tick;
   logic                fall;
   logic                load;
   logic                accept;
   logic                hold_full_next;
   logic [PW-1:0]       pos_next;
   logic [FW-1:0]       frame_new;

   // Edge timing, next bit position and the next frame image built from the holding register
   always_comb begin
      tick      = en && (div == DIV_LAST);
      fall      = tick && i2s_bclk;
      pos_next  = (pos == P_LAST) ? '0 : pos + 1'b1;
      load      = fall && (pos == P_LAST);
      accept    = sample_valid && sample_ready;
      // The load looks at hold_full before this cycle's accept; accept is
      // only possible while the register is empty, so the two never collide.
      hold_full_next = hold_full;
      if (load) begin
         hold_full_next = 1'b0;
      end
      if (accept) begin
         hold_full_next = 1'b1;
      end
      frame_new = '0;
      frame_new[FW-1 -: SAMPLE_W]        = hold_l;
      frame_new[SLOT_BITS-1 -: SAMPLE_W] = hold_r;
   end

   // Bit-clock divider; disabling returns it to the idle phase immediately
   always_ff @(posedge clk_sys) begin
      if (RESET || !en) begin
         div      <= '0;
         i2s_bclk <= 1'b0;
      end else begin
         div <= tick ? '0 : div + 1'b1;
         if (tick) begin
            i2s_bclk <= ~i2s_bclk;
         end
      end
   end

   // Serialiser: on each BCLK fall advance the position, shift data and drive WS
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         pos         <= P_LAST;
         frame_sr    <= '0;
         i2s_data    <= 1'b0;
         i2s_ws      <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         if (!en) begin
            pos      <= P_LAST;
            i2s_data <= 1'b0;
            i2s_ws   <= 1'b0;
         end else if (fall) begin
            pos    <= pos_next;
            i2s_ws <= (pos_next >= WS_LO) && (pos_next <= WS_HI);
            if (load) begin
               frame_start <= 1'b1;
               if (hold_full) begin
                  i2s_data <= frame_new[FW-1];
                  frame_sr <= {frame_new[FW-2:0], 1'b0};
               end else begin
                  // Underrun sends silence rather than repeating the last pair
                  underrun <= 1'b1;
                  i2s_data <= 1'b0;
                  frame_sr <= '0;
               end
            end else begin
               i2s_data <= frame_sr[FW-1];
               frame_sr <= {frame_sr[FW-2:0], 1'b0};
            end
         end
      end
   end

   // Holding register and registered ready; survives en=0 so the handshake keeps working
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         hold_l       <= '0;
         hold_r       <= '0;
         hold_full    <= 1'b0;
         sample_ready <= 1'b1;
      end else begin
         if (accept) begin
            hold_l <= sample_l;
            hold_r <= sample_r;
         end
         hold_full    <= hold_full_next;
         sample_ready <= ~hold_full_next;
      end
   end

endmodule
